// File: rtl/pio_loader.sv
// rtl/pio_loader.sv - boot-time PIO program/config loader with host pass-through
module pio_loader #(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        plen,
    input  logic [1:0]        machine,
    input  logic [23:0]       div,
    input  logic [31:0]       pin_grps,
    input  logic [4:0]        sideset_bits,
    input  logic [31:0]       shift_cfg,
    input  logic [3:0]        en_mask,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [3:0]        host_action,
    input  logic [ADDR_W-1:0] host_index,
    input  logic [1:0]        host_mindex,
    input  logic [31:0]       host_din,
    output logic [3:0]        action,
    output logic [ADDR_W-1:0] index,
    output logic [1:0]        mindex,
    output logic [31:0]       din,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_SIDES = 4'd8;
    localparam logic [3:0] ACT_SHIFT = 4'd10;
    localparam logic [6:0] DEPTH_LIM = 7'(PROG_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_PRIME, S_INSTR, S_PEND, S_DIV,
        S_GRPS, S_SIDES, S_SHIFT, S_EN, S_FIN
    } state_t;

    state_t            state;
    logic [5:0]        plen_q;
    logic [1:0]        mach_q;
    logic [23:0]       div_q;
    logic [31:0]       grps_q;
    logic [4:0]        sides_q;
    logic [31:0]       shift_q;
    logic [3:0]        en_q;
    logic              err_q;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              plen_ok;

    assign plen_ok    = (plen != 6'd0) && ({1'b0, plen} <= DEPTH_LIM);
    assign last_addr  = ADDR_W'(plen_q - 6'd1);
    // ROM address runs one word ahead of the INSTR stream and parks on the last word
    assign next_addr  = (prog_addr == last_addr) ? prog_addr : prog_addr + 1'b1;
    assign host_ready = (state == S_IDLE) && !start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            action    <= ACT_NONE;
            index     <= '0;
            mindex    <= '0;
            din       <= '0;
            prog_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            plen_q    <= '0;
            mach_q    <= '0;
            div_q     <= '0;
            grps_q    <= '0;
            sides_q   <= '0;
            shift_q   <= '0;
            en_q      <= '0;
            err_q     <= 1'b0;
            word_cnt  <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            action <= ACT_NONE;
            index  <= '0;
            din    <= '0;
            mindex <= mach_q;
            case (state)
                S_IDLE: begin
                    mindex <= '0;
                    if (start) begin
                        plen_q    <= plen;
                        mach_q    <= machine;
                        div_q     <= div;
                        grps_q    <= pin_grps;
                        sides_q   <= sideset_bits;
                        shift_q   <= shift_cfg;
                        en_q      <= en_mask;
                        err_q     <= !plen_ok;
                        busy      <= 1'b1;
                        prog_addr <= '0;
                        word_cnt  <= '0;
                        state     <= plen_ok ? S_PRIME : S_FIN;
                    end else if (host_valid) begin
                        action <= host_action;
                        index  <= host_index;
                        mindex <= host_mindex;
                        din    <= host_din;
                    end
                end
                S_PRIME: begin
                    prog_addr <= next_addr;
                    state     <= S_INSTR;
                end
                S_INSTR: begin
                    action    <= ACT_INSTR;
                    index     <= word_cnt;
                    din       <= {16'h0, prog_data};
                    prog_addr <= next_addr;
                    if (word_cnt == last_addr) begin
                        state <= S_PEND;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                S_PEND: begin
                    action <= ACT_PEND;
                    din    <= {26'h0, plen_q - 6'd1};
                    state  <= S_DIV;
                end
                S_DIV: begin
                    action <= ACT_DIV;
                    din    <= {8'h0, div_q};
                    state  <= S_GRPS;
                end
                S_GRPS: begin
                    action <= ACT_GRPS;
                    din    <= grps_q;
                    state  <= S_SIDES;
                end
                S_SIDES: begin
                    action <= ACT_SIDES;
                    din    <= {27'h0, sides_q};
                    state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    action <= ACT_SHIFT;
                    din    <= shift_q;
                    state  <= S_EN;
                end
                S_EN: begin
                    action <= ACT_EN;
                    din    <= {28'h0, en_q};
                    state  <= S_FIN;
                end
                S_FIN: begin
                    done  <= 1'b1;
                    err   <= err_q;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_loader.sv
// tb/tb_pio_loader.sv - randomized bench for pio_loader against a cycle-offset model
module tb_pio_loader;
    localparam int PROG_DEPTH = 32;
    localparam int ADDR_W     = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [5:0]        plen = '0;
    logic [1:0]        machine = '0;
    logic [23:0]       div = '0;
    logic [31:0]       pin_grps = '0;
    logic [4:0]        sideset_bits = '0;
    logic [31:0]       shift_cfg = '0;
    logic [3:0]        en_mask = '0;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic              host_valid = 1'b0;
    logic              host_ready;
    logic [3:0]        host_action = '0;
    logic [ADDR_W-1:0] host_index = '0;
    logic [1:0]        host_mindex = '0;
    logic [31:0]       host_din = '0;
    logic [3:0]        action;
    logic [ADDR_W-1:0] index;
    logic [1:0]        mindex;
    logic [31:0]       din;
    logic              busy, done, err;

    int total = 0;
    int bad = 0;
    logic [15:0] rom [PROG_DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) prog_data <= rom[prog_addr];

    pio_loader #(.PROG_DEPTH(PROG_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .plen(plen), .machine(machine),
        .div(div), .pin_grps(pin_grps), .sideset_bits(sideset_bits),
        .shift_cfg(shift_cfg), .en_mask(en_mask), .prog_addr(prog_addr),
        .prog_data(prog_data), .host_valid(host_valid), .host_ready(host_ready),
        .host_action(host_action), .host_index(host_index), .host_mindex(host_mindex),
        .host_din(host_din), .action(action), .index(index), .mindex(mindex),
        .din(din), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] cfg_act(input int j);
        case (j)
            0: return 4'd2;
            1: return 4'd7;
            2: return 4'd5;
            3: return 4'd8;
            4: return 4'd10;
            default: return 4'd6;
        endcase
    endfunction

    // Model: a load is a timeline indexed by edges since acceptance (k)
    bit                m_active = 0;
    bit                m_legal = 0;
    int                m_k = 0;
    int                m_plen = 0;
    int                m_last = 0;
    logic [1:0]        m_mach = '0;
    logic [31:0]       m_cfg [6];
    logic [3:0]        e_act = '0;
    logic [ADDR_W-1:0] e_idx = '0;
    logic [1:0]        e_mi = '0;
    logic [31:0]       e_din = '0;
    bit                e_busy = 0, e_done = 0, e_err = 0, e_pa_chk = 1;
    int                e_pa = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 0;
            e_act = '0; e_idx = '0; e_mi = '0; e_din = '0;
            e_busy = 0; e_done = 0; e_err = 0; e_pa_chk = 1; e_pa = 0;
        end else begin
            e_act = '0; e_idx = '0; e_mi = '0; e_din = '0;
            e_done = 0; e_err = 0; e_busy = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_k = 0;
                    m_plen = int'(plen);
                    m_legal = (m_plen >= 1) && (m_plen <= PROG_DEPTH);
                    m_mach = machine;
                    m_cfg[0] = 32'(m_plen - 1);
                    m_cfg[1] = {8'h0, div};
                    m_cfg[2] = pin_grps;
                    m_cfg[3] = {27'h0, sideset_bits};
                    m_cfg[4] = shift_cfg;
                    m_cfg[5] = {28'h0, en_mask};
                end else if (host_valid) begin
                    e_act = host_action; e_idx = host_index;
                    e_mi = host_mindex; e_din = host_din;
                end
            end else begin
                m_k++;
            end
            if (m_active) begin
                m_last = m_legal ? m_plen + 7 : 0;
                if (m_k > m_last) begin
                    e_done = 1; e_err = !m_legal; m_active = 0; e_pa_chk = 0;
                end else begin
                    e_busy = 1; e_pa_chk = 1;
                    e_pa = !m_legal ? 0 : (m_k < m_plen - 1 ? m_k : m_plen - 1);
                    if (m_legal && m_k >= 2 && m_k <= m_plen + 1) begin
                        e_act = 4'd1; e_idx = ADDR_W'(m_k - 2);
                        e_din = {16'h0, rom[m_k - 2]}; e_mi = m_mach;
                    end else if (m_legal && m_k >= m_plen + 2) begin
                        e_act = cfg_act(m_k - m_plen - 2);
                        e_din = m_cfg[m_k - m_plen - 2]; e_mi = m_mach;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("action", action, e_act);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("host_ready", host_ready, !m_active && !start);
        if (e_act != 4'd0) begin
            chk("index", index, e_idx);
            chk("mindex", mindex, e_mi);
            chk("din", din, e_din);
        end
        if (e_pa_chk) chk("prog_addr", prog_addr, e_pa);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg();
        machine = 2'($urandom); div = 24'($urandom); pin_grps = $urandom;
        sideset_bits = 5'($urandom); shift_cfg = $urandom; en_mask = 4'($urandom);
    endtask

    initial begin
        for (int i = 0; i < PROG_DEPTH; i++) rom[i] = 16'($urandom);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_action", action, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", din, 0);
        tick();
        reset = 1'b0;

        // host PULL pass-through
        host_valid = 1; host_action = 4'd3; host_index = '0; host_din = 32'd1;
        @(negedge clk);
        chk("pull_ready", host_ready, 1);
        tick();
        host_valid = 0;
        @(negedge clk);
        chk("pull_act", action, 3);
        chk("pull_din", din, 1);
        tick();
        @(negedge clk);
        chk("pull_none", action, 0);
        tick();

        // directed plen=4 load
        rom[0] = 16'hE081; rom[1] = 16'hA0C3; rom[2] = 16'h8020; rom[3] = 16'h0000;
        plen = 6'd4; machine = 0; div = 0; pin_grps = 32'h20100000;
        sideset_bits = 0; shift_cfg = 0; en_mask = 4'd1;
        start = 1;
        for (int n = 0; n <= 12; n++) begin
            tick();
            start = 0;
            @(negedge clk);
            case (n)
                0:  chk("d_busy0", busy, 1);
                2:  begin chk("d_i0", action, 1); chk("d_i0_din", din, 32'hE081); end
                3:  chk("d_i1_din", din, 32'hA0C3);
                5:  begin chk("d_i3_idx", index, 3); chk("d_i3_din", din, 0); end
                6:  begin chk("d_pend", action, 2); chk("d_pend_din", din, 3); end
                8:  begin chk("d_grps", action, 5); chk("d_grps_din", din, 32'h20100000); end
                11: begin chk("d_en", action, 6); chk("d_en_din", din, 1); chk("d_busy11", busy, 1); end
                12: begin chk("d_done", done, 1); chk("d_err", err, 0); chk("d_busy12", busy, 0); end
                default: ;
            endcase
        end
        tick();

        // illegal lengths
        for (int t = 0; t < 2; t++) begin
            plen = (t == 0) ? 6'd0 : 6'd33;
            rand_cfg();
            start = 1;
            tick();
            start = 0;
            @(negedge clk);
            chk("il_busy", busy, 1);
            tick();
            @(negedge clk);
            chk("il_done", done, 1);
            chk("il_err", err, 1);
            chk("il_busy_end", busy, 0);
            tick();
        end

        // start beats host; requests while busy ignored; host served after done
        for (int i = 0; i < PROG_DEPTH; i++) rom[i] = 16'($urandom);
        plen = 6'd3; rand_cfg();
        start = 1; host_valid = 1; host_action = 4'd4; host_din = 32'h55;
        @(negedge clk);
        chk("sh_ready", host_ready, 0);
        for (int n = 0; n <= 12; n++) begin
            tick();
            start = (n < 5);
            @(negedge clk);
            if (n == 11) begin
                chk("sh_done", done, 1);
                chk("sh_ready_after", host_ready, 1);
            end
            if (n == 12) chk("sh_host_act", action, 4);
        end
        tick();
        host_valid = 0;
        tick();

        // full-depth load with config inputs churning after acceptance
        plen = 6'd32; rand_cfg(); div = 24'h123456;
        start = 1;
        for (int n = 0; n <= 41; n++) begin
            tick();
            start = 0;
            plen = 6'($urandom); rand_cfg();
            @(negedge clk);
            if (n == 33) begin chk("f_idx31", index, 31); chk("f_pa", prog_addr, 31); end
            if (n == 34) begin chk("f_pend", action, 2); chk("f_pend_din", din, 31); end
            if (n == 35) chk("f_div", din, 32'h123456);
            if (n == 40) chk("f_done", done, 1);
        end
        tick();

        // reset after the 2nd INSTR, then a clean reload
        plen = 6'd4; rand_cfg();
        start = 1;
        for (int n = 0; n <= 3; n++) begin
            tick();
            start = 0;
        end
        #1 reset = 1;
        #1;
        chk("ab_action", action, 0);
        chk("ab_busy", busy, 0);
        chk("ab_din", din, 0);
        chk("ab_pa", prog_addr, 0);
        tick();
        reset = 0;
        repeat (14) tick();
        plen = 6'd4; rand_cfg(); en_mask = 4'd9;
        start = 1;
        for (int n = 0; n <= 12; n++) begin
            tick();
            start = 0;
            @(negedge clk);
            if (n == 11) begin chk("rl_en", action, 6); chk("rl_en_din", din, 9); end
            if (n == 12) chk("rl_done", done, 1);
        end
        tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom % 700 == 0);
            start = ($urandom % 12 == 0);
            plen = ($urandom % 8 == 0) ? 6'($urandom) : 6'(1 + $urandom % 32);
            rand_cfg();
            host_valid = $urandom % 2;
            host_action = 4'($urandom); host_index = ADDR_W'($urandom);
            host_mindex = 2'($urandom); host_din = $urandom;
            tick();
        end
        reset = 0; start = 0; host_valid = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pio_loader.md
Name: pio_loader

Overview:
- Sequencer that configures one PIO block through its action/index/mindex/din port.
- On `start`, it streams the program from a synchronous program ROM as INSTR actions.
- It then issues PEND, DIV, GRPS, SIDES, SHIFT and EN in a fixed order, one action per cycle.
- When idle, it arbitrates the same port to a host pass-through channel (PULL/PUSH/IMM etc.), so one PIO is shared between the boot-time loader and runtime software.

Parameters:
- PROG_DEPTH, 32, maximum program words; legal plen is 1..PROG_DEPTH.
- ADDR_W, 5, width of prog_addr and index.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load
- plen  in  6  program length in words
- machine  in  2  target state machine, driven on mindex
- div  in  24  clock divider value
- pin_grps  in  32  pin group word
- sideset_bits  in  5  side-set bit count
- shift_cfg  in  32  shift/threshold/autopush word
- en_mask  in  4  machine enable mask, sent with EN
- prog_addr  out  ADDR_W  ROM address (registered)
- prog_data  in  16  ROM data, valid the cycle after prog_addr is presented
- host_valid  in  1  host action request
- host_ready  out  1  host request accepted this cycle (combinational)
- host_action  in  4  host action code
- host_index  in  ADDR_W  host index
- host_mindex  in  2  host machine index
- host_din  in  32  host data
- action  out  4  PIO action (registered)
- index  out  ADDR_W  PIO index (registered)
- mindex  out  2  PIO machine index (registered)
- din  out  32  PIO data (registered)
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load
- err  out  1  one-cycle pulse with done when plen is illegal

Behaviour:
- Action codes: NONE=0, INSTR=1, PEND=2, GRPS=5, EN=6, DIV=7, SIDES=8, SHIFT=10.
- Reset (async): state IDLE; action, index, mindex, din, prog_addr, busy, done, err all 0.
- States: IDLE, PRIME, INSTR, PEND, DIV, GRPS, SIDES, SHIFT, EN, FIN.
- IDLE:
  - host_ready = ~start.
  - host_valid & host_ready → host fields registered onto action/index/mindex/din next edge, held exactly one cycle; otherwise action = NONE.
- Start acceptance (edge E0, start=1 in IDLE):
  - Snapshot all config inputs, including plen and machine.
  - busy←1, prog_addr←0.
  - If plen==0 or plen>PROG_DEPTH: go to FIN, no actions issued.
  - Otherwise go to PRIME.
- Start while busy is ignored; config input changes after E0 are ignored.
- Start and host_valid in the same IDLE cycle: start wins and the host request is not accepted.
- ROM pipeline:
  - prog_addr increments each cycle from PRIME until plen-1, then holds.
  - INSTR for word i appears on action during the cycle after edge E(2+i), with index=i and din={16'h0, prog_data}.
  - INSTR actions are back-to-back, with no NONE gaps.
- Config actions, one cycle each, starting immediately after the last INSTR:
  - PEND, din=plen-1, at E(2+plen)
  - DIV, din={8'h0,div}
  - GRPS, din=pin_grps
  - SIDES, din={27'h0,sideset_bits}
  - SHIFT, din=shift_cfg
  - EN, din={28'h0,en_mask}, at E(7+plen)
- mindex = latched machine for every loader action; index=0 for all non-INSTR actions.
- FIN (edge E(8+plen), or E1 for illegal plen):
  - action←NONE, din←0, done←1 for one cycle; err←1 only if plen was illegal.
  - busy←0 on the same edge.
  - State returns to IDLE, so host_ready can be 1 in the cycle after the done pulse.
- Reset mid-load: immediate return to IDLE with all outputs 0; EN is never issued for an aborted load.

Test Plan:
- Reset, then host_valid with PULL(3), host_din=1 → host_ready=1; next cycle action=3, din=1 for exactly one cycle, then NONE.
- plen=4, machine=0, ROM={E081,A0C3,8020,0000}, div=0, pin_grps=20100000, shift_cfg=0, en_mask=1, start at E0 →
  - INSTR index 0..3 after E2..E5 with din=E081, A0C3, 8020, 0000.
  - PEND din=3 after E6, then DIV 0, GRPS 20100000, SIDES 0, SHIFT 0, EN 1 after E11.
  - done=1 after E12, err=0, busy high after E0..E11.
- plen=0 and plen=33 → no non-NONE action; done=err=1 one cycle after E1; busy high one cycle.
- start and host_valid in the same cycle → host_ready=0 and the load proceeds. A second start and host_valid during busy → ignored and host_ready=0. The host request is accepted in the first IDLE cycle after done.
- plen=32, changing div and plen mid-load → 32 back-to-back INSTRs, index 0..31, prog_addr stops at 31; PEND din=31; DIV uses the snapshot value.
- Assert reset after the 2nd INSTR of a plen=4 load → all outputs 0 immediately; no EN issued. A subsequent start performs a full, correct load.
